stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Run-control sequencer for the stopwatch counter core. It debounces two push-buttons (start/stop and lap/clear) sampled on the 100 Hz core clock, and runs a four-state FSM. The FSM drives the core's count enable and clear, and freezes a lap snapshot for the display path. It sits between the board buttons and the counter core. Its display outputs feed the BCD-to-segment driver.

## Interface
- DEB_CYC, 2: consecutive stable synchronized samples required before a debounced level changes (1..15).
- clk_core  input  1  core clock, 100 Hz
- rst  input  1  asynchronous, active-low reset for all state
- btn_ss  input  1  raw start/stop button, active high, asynchronous to clk_core
- btn_lc  input  1  raw lap/clear button, active high, asynchronous to clk_core
- min_i  input  8  live minutes from counter core, BCD {tens, units}
- sec_i  input  8  live seconds from counter core, BCD
- ms_10_i  input  8  live hundredths from counter core, BCD
- cnt_en  output  1  count enable to counter core
- cnt_rst_n  output  1  active-low clear to counter core
- disp_min  output  8  displayed minutes
- disp_sec  output  8  displayed seconds
- disp_ms_10  output  8  displayed hundredths
- state_o  output  2  current FSM state encoding
- lap_flag  output  1  high while a lap snapshot is displayed

## Operation
- Each button passes through a 2-flop synchronizer and then a debouncer.
  - Debouncer: a 4-bit counter increments on every edge where the synchronized sample differs from the debounced level. It resets whenever they agree.
  - When the counter would reach DEB_CYC, the debounced level takes the sample and the counter resets.
- Event = rising edge of the debounced level: a single-cycle pulse, ev_ss or ev_lc. Falling edges generate nothing.
- FSM states: IDLE=2'b00, RUN=2'b01, PAUSE=2'b10, LAP=2'b11.
  - IDLE: ev_ss -> RUN. ev_lc ignored.
  - RUN: ev_ss -> PAUSE. ev_lc -> LAP, capturing min_i/sec_i/ms_10_i into the lap registers on the same edge.
  - LAP: ev_ss -> PAUSE. ev_lc -> RUN, releasing the display.
  - PAUSE: ev_ss -> RUN. ev_lc -> IDLE with a clear pulse.
- ev_ss and ev_lc in the same cycle: ev_ss takes priority and ev_lc is discarded.
- cnt_en = 1 in RUN and LAP, 0 in IDLE and PAUSE. It is decoded from the state register, so it is glitch-free.
- cnt_rst_n:
  - Registered.
  - Driven 0 for exactly one cycle following the PAUSE->IDLE transition edge.
  - Otherwise 1, except during reset (see Timing).
- Display outputs are a combinational mux:
  - In LAP: the lap registers.
  - In every other state: the live inputs, passed straight through.
- lap_flag = (state == LAP).
- Counter wrap (99:59.99 -> 00:00.00) is the core's business. The controller does not react to it.

## Timing
- Reset (rst low) values:
  - state IDLE; cnt_en 0; cnt_rst_n 0, so the core is held clear during reset.
  - Lap registers, synchronizers, debounced levels and debounce counters all 0.
  - lap_flag 0; disp_* follow the live inputs.
- cnt_rst_n returns to 1 on the first clk_core edge after rst deasserts.
- Button latency: a raw press stable from edge k onward is seen as follows.
  - Synchronizer output high after edge k+1.
  - Debounced level high after edge k+1+DEB_CYC.
  - FSM changes state at edge k+2+DEB_CYC; with DEB_CYC=2, that is edge k+4.
- Pulses shorter than DEB_CYC synchronized samples produce no event.
- Clear: the clear pulse is asserted for the cycle after the transition edge. The core sees rst low asynchronously and returns to zero.
- Lap capture: uses the input values present in the cycle of the transition edge.
- Reset mid-operation (any state, even with cnt_rst_n pulsing): immediate return to the reset values above. Any in-flight debounce progress is lost.

## Configuration
- STOPWATCH_LAP_EN defined:
  - LAP state, lap registers and lap_flag are implemented as described.
- STOPWATCH_LAP_EN undefined:
  - No lap registers; LAP is unreachable.
  - ev_lc in RUN is ignored; ev_lc in PAUSE still clears to IDLE.
  - disp_* always equal the live inputs; lap_flag is tied 0.
  - The state encoding is unchanged.

## Test plan
- Reset: hold rst low 3 cycles with buttons idle -> state_o=00, cnt_en=0, cnt_rst_n=0. One edge after release -> cnt_rst_n=1.
- Start: DEB_CYC=2, btn_ss high from edge k for 6 cycles -> state_o=01 and cnt_en=1 at edge k+4, and not earlier. Releasing the button causes no further change.
- Bounce: btn_ss high for 1 cycle, low for 1, high for 1, then low -> no state change, cnt_en stays 0.
- Lap (macro defined): in RUN with the core at min_i=8'h01, sec_i=8'h23, ms_10_i=8'h45, press btn_lc.
  - Expected: lap_flag=1 and disp = 01/23/45 while the inputs keep advancing; cnt_en stays 1.
  - A second btn_lc press -> state 01 and disp back to live.
- Stop and clear: RUN -> btn_ss -> PAUSE (cnt_en=0) -> btn_lc -> IDLE.
  - Expected: cnt_rst_n=0 for exactly one cycle, then 1.
  - Simultaneous btn_ss+btn_lc in PAUSE -> RUN, with no clear pulse.
- Macro undefined: btn_lc press in RUN -> state stays 01, lap_flag=0, disp tracks the inputs.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// ============================================================================
//  stopwatch_ctrl : button debounce + run/pause/lap/clear sequencer
//  Optional lap feature enabled by defining STOPWATCH_LAP_EN.
//  Revision 1.0
// ============================================================================
`default_nettype none

module stopwatch_ctrl #(
   parameter int DEB_CYC = 2
) (
   input  logic       clk_core,
   input  logic       rst,
   input  logic       btn_ss,
   input  logic       btn_lc,
   input  logic [7:0] min_i,
   input  logic [7:0] sec_i,
   input  logic [7:0] ms_10_i,
   output logic       cnt_en,
   output logic       cnt_rst_n,
   output logic [7:0] disp_min,
   output logic [7:0] disp_sec,
   output logic [7:0] disp_ms_10,
   output logic [1:0] state_o,
   output logic       lap_flag
);

   localparam logic [3:0] C_DEB_CNT = 4'(DEB_CYC);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_RUN   = 2'b01,
      S_PAUSE = 2'b10,
      S_LAP   = 2'b11
   } state_t;

   logic [1:0] btn_raw;
   logic [1:0] ev;
   logic       ev_ss;
   logic       ev_lc;

   assign btn_raw = {btn_lc, btn_ss};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_deb
         logic       sync1_q;
         logic       sync2_q;
         logic       level_q;
         logic       level_prev_q;
         logic [3:0] cnt_q;
         logic [3:0] cnt_inc;

         assign cnt_inc = cnt_q + 4'd1;

         always_ff @(posedge clk_core or negedge rst) begin
            if (!rst) begin
               sync1_q      <= 1'b0;
               sync2_q      <= 1'b0;
               level_q      <= 1'b0;
               level_prev_q <= 1'b0;
               cnt_q        <= 4'd0;
            end else begin
               sync1_q      <= btn_raw[gi];
               sync2_q      <= sync1_q;
               level_prev_q <= level_q;
               if (sync2_q == level_q) begin
                  cnt_q <= 4'd0;
               end else if (cnt_inc == C_DEB_CNT) begin
                  level_q <= sync2_q;
                  cnt_q   <= 4'd0;
               end else begin
                  cnt_q <= cnt_inc;
               end
            end
         end

         // Rising edge of the debounced level only; releases are silent.
         assign ev[gi] = level_q & ~level_prev_q;
      end
   endgenerate

   assign ev_ss = ev[0];
   assign ev_lc = ev[1];

   state_t state_q;
   logic   cnt_rst_n_q;

   always_ff @(posedge clk_core or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         cnt_rst_n_q <= 1'b0;
      end else begin
         cnt_rst_n_q <= 1'b1;
         case (state_q)
            S_IDLE: begin
               if (ev_ss) state_q <= S_RUN;
            end
            S_RUN: begin
               if (ev_ss) begin
                  state_q <= S_PAUSE;
`ifdef STOPWATCH_LAP_EN
               end else if (ev_lc) begin
                  state_q <= S_LAP;
`endif
               end
            end
            S_PAUSE: begin
               if (ev_ss) begin
                  state_q <= S_RUN;
               end else if (ev_lc) begin
                  state_q     <= S_IDLE;
                  cnt_rst_n_q <= 1'b0;
               end
            end
            S_LAP: begin
               if (ev_ss)      state_q <= S_PAUSE;
               else if (ev_lc) state_q <= S_RUN;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign state_o   = state_q;
   assign cnt_en    = (state_q == S_RUN) || (state_q == S_LAP);
   assign cnt_rst_n = cnt_rst_n_q;

`ifdef STOPWATCH_LAP_EN
   logic [7:0] lap_min_q;
   logic [7:0] lap_sec_q;
   logic [7:0] lap_ms_10_q;

   always_ff @(posedge clk_core or negedge rst) begin
      if (!rst) begin
         lap_min_q   <= 8'h00;
         lap_sec_q   <= 8'h00;
         lap_ms_10_q <= 8'h00;
      end else if ((state_q == S_RUN) && ev_lc && !ev_ss) begin
         lap_min_q   <= min_i;
         lap_sec_q   <= sec_i;
         lap_ms_10_q <= ms_10_i;
      end
   end

   assign lap_flag   = (state_q == S_LAP);
   assign disp_min   = lap_flag ? lap_min_q   : min_i;
   assign disp_sec   = lap_flag ? lap_sec_q   : sec_i;
   assign disp_ms_10 = lap_flag ? lap_ms_10_q : ms_10_i;
`else
   assign lap_flag   = 1'b0;
   assign disp_min   = min_i;
   assign disp_sec   = sec_i;
   assign disp_ms_10 = ms_10_i;
`endif

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
// ============================================================================
//  tb_stopwatch_ctrl : directed self-checking bench for stopwatch_ctrl
//  Revision 1.0
// ============================================================================
`default_nettype none

module tb_stopwatch_ctrl;

   logic       clk_core = 1'b0;
   logic       rst      = 1'b0;
   logic       btn_ss   = 1'b0;
   logic       btn_lc   = 1'b0;
   logic [7:0] min_i    = 8'h00;
   logic [7:0] sec_i    = 8'h00;
   logic [7:0] ms_10_i  = 8'h00;
   logic       cnt_en;
   logic       cnt_rst_n;
   logic [7:0] disp_min;
   logic [7:0] disp_sec;
   logic [7:0] disp_ms_10;
   logic [1:0] state_o;
   logic       lap_flag;

   int n_checks = 0;
   int n_errors = 0;

   stopwatch_ctrl #(.DEB_CYC(2)) u_dut (
      .clk_core   (clk_core),
      .rst        (rst),
      .btn_ss     (btn_ss),
      .btn_lc     (btn_lc),
      .min_i      (min_i),
      .sec_i      (sec_i),
      .ms_10_i    (ms_10_i),
      .cnt_en     (cnt_en),
      .cnt_rst_n  (cnt_rst_n),
      .disp_min   (disp_min),
      .disp_sec   (disp_sec),
      .disp_ms_10 (disp_ms_10),
      .state_o    (state_o),
      .lap_flag   (lap_flag)
   );

   always #5 clk_core = ~clk_core;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
   task automatic tick();
      @(posedge clk_core);
      #1;
   endtask

   task automatic press(input logic ss, input logic lc);
      btn_ss = ss;
      btn_lc = lc;
      repeat (6) tick();
      btn_ss = 1'b0;
      btn_lc = 1'b0;
      repeat (8) tick();
   endtask

   logic saw_clear;

   initial begin
      // Reset
      min_i = 8'h12; sec_i = 8'h34; ms_10_i = 8'h56;
      rst = 1'b0;
      repeat (3) tick();
      check("rst_state", {6'd0, state_o}, 8'h00);
      check("rst_cnt_en", {7'd0, cnt_en}, 8'h00);
      check("rst_cnt_rst_n", {7'd0, cnt_rst_n}, 8'h00);
      check("rst_lap_flag", {7'd0, lap_flag}, 8'h00);
      check("rst_disp_sec", disp_sec, 8'h34);
      rst = 1'b1;
      tick();
      check("rst_release_cnt_rst_n", {7'd0, cnt_rst_n}, 8'h01);

      // Bounce: 1 high, 1 low, 1 high, then low
      btn_ss = 1'b1; tick();
      btn_ss = 1'b0; tick();
      btn_ss = 1'b1; tick();
      btn_ss = 1'b0;
      repeat (8) tick();
      check("bounce_state", {6'd0, state_o}, 8'h00);
      check("bounce_cnt_en", {7'd0, cnt_en}, 8'h00);

      // Start: raw high sampled from edge k; state changes at edge k+4
      btn_ss = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("start_early_state", {6'd0, state_o}, 8'h00);
      end
      tick();
      check("start_state", {6'd0, state_o}, 8'h01);
      check("start_cnt_en", {7'd0, cnt_en}, 8'h01);
      tick();
      btn_ss = 1'b0;
      repeat (8) tick();
      check("start_release_state", {6'd0, state_o}, 8'h01);

      // Lap / lap-disabled behaviour in RUN
      min_i = 8'h01; sec_i = 8'h23; ms_10_i = 8'h45;
      press(1'b0, 1'b1);
      min_i = 8'h02; sec_i = 8'h34; ms_10_i = 8'h56;
      #1;
`ifdef STOPWATCH_LAP_EN
      check("lap_state", {6'd0, state_o}, 8'h03);
      check("lap_flag", {7'd0, lap_flag}, 8'h01);
      check("lap_disp_min", disp_min, 8'h01);
      check("lap_disp_sec", disp_sec, 8'h23);
      check("lap_disp_ms", disp_ms_10, 8'h45);
      check("lap_cnt_en", {7'd0, cnt_en}, 8'h01);
      press(1'b0, 1'b1);
      check("unlap_state", {6'd0, state_o}, 8'h01);
      check("unlap_flag", {7'd0, lap_flag}, 8'h00);
      check("unlap_disp_sec", disp_sec, 8'h34);
      check("unlap_disp_ms", disp_ms_10, 8'h56);
`else
      check("nolap_state", {6'd0, state_o}, 8'h01);
      check("nolap_flag", {7'd0, lap_flag}, 8'h00);
      check("nolap_disp_min", disp_min, 8'h02);
      check("nolap_disp_sec", disp_sec, 8'h34);
      check("nolap_disp_ms", disp_ms_10, 8'h56);
      check("nolap_cnt_en", {7'd0, cnt_en}, 8'h01);
`endif

      // Stop
      press(1'b1, 1'b0);
      check("pause_state", {6'd0, state_o}, 8'h02);
      check("pause_cnt_en", {7'd0, cnt_en}, 8'h00);

      // Clear: exactly one low cycle after the PAUSE->IDLE edge
      btn_lc = 1'b1;
      repeat (4) tick();
      check("clear_pre_state", {6'd0, state_o}, 8'h02);
      check("clear_pre_rst_n", {7'd0, cnt_rst_n}, 8'h01);
      tick();
      check("clear_state", {6'd0, state_o}, 8'h00);
      check("clear_pulse", {7'd0, cnt_rst_n}, 8'h00);
      tick();
      check("clear_pulse_end", {7'd0, cnt_rst_n}, 8'h01);
      btn_lc = 1'b0;
      repeat (8) tick();
      check("clear_idle_rst_n", {7'd0, cnt_rst_n}, 8'h01);
      check("clear_idle_state", {6'd0, state_o}, 8'h00);

      // Simultaneous buttons in PAUSE: start/stop wins, no clear
      press(1'b1, 1'b0);
      press(1'b1, 1'b0);
      check("pause2_state", {6'd0, state_o}, 8'h02);
      saw_clear = 1'b0;
      btn_ss = 1'b1;
      btn_lc = 1'b1;
      for (int i = 0; i < 14; i++) begin
         if (i == 6) begin
            btn_ss = 1'b0;
            btn_lc = 1'b0;
         end
         tick();
         if (cnt_rst_n !== 1'b1) saw_clear = 1'b1;
      end
      check("both_state", {6'd0, state_o}, 8'h01);
      check("both_no_clear", {7'd0, saw_clear}, 8'h00);

      // Asynchronous reset mid-run
      btn_ss = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
      check("midrst_state", {6'd0, state_o}, 8'h00);
      check("midrst_cnt_en", {7'd0, cnt_en}, 8'h00);
      check("midrst_cnt_rst_n", {7'd0, cnt_rst_n}, 8'h00);
      btn_ss = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      check("midrst_release_rst_n", {7'd0, cnt_rst_n}, 8'h01);
      repeat (8) tick();
      check("midrst_idle_state", {6'd0, state_o}, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
